// File: rtl/key_press_conditioner.sv
// key_press_conditioner: turns raw active-low push buttons into a debounced
// level plus single-cycle press, release and long-press events per key.
// Each key has its own synchronizer, debounce counter, level FSM and hold
// counter. All outputs are registered.
module key_press_conditioner #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_keys_n,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_level
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DC_ONE = DW'(1);
  localparam logic [DW-1:0] DC_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HC_ONE = HW'(1);
  localparam logic [HW-1:0] HC_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HC_PRE = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] key_s;

  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [DW-1:0]     dc_q    [N_KEYS];
  logic [DW-1:0]     dc_d    [N_KEYS];
  logic [HW-1:0]     hc_q    [N_KEYS];
  logic [HW-1:0]     hc_d    [N_KEYS];

  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] level_q, level_d;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_keys_n;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = ~sync2_q;

  // Per-key state, counters and registered event outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        state_q[k] <= RELEASED;
        dc_q[k]    <= '0;
        hc_q[k]    <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      level_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        dc_q[k]    <= dc_d[k];
        hc_q[k]    <= hc_d[k];
      end
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
    end
  end

  // Next-state, counter and event logic for every key.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    level_d   = '0;
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      state_d[k] = state_q[k];
      dc_d[k]    = dc_q[k];
      hc_d[k]    = hc_q[k];

      // Hold time runs through release bounces so a bounce does not restart
      // the long-press window; an accepted release below overrides this.
      if ((state_q[k] == PRESSED || state_q[k] == RELEASE_CHK) && hc_q[k] < HC_MAX) begin
        hc_d[k]   = hc_q[k] + HC_ONE;
        long_d[k] = (hc_q[k] == HC_PRE);
      end

      unique case (state_q[k])
        RELEASED: begin
          if (key_s[k]) begin
            state_d[k] = PRESS_CHK;
            dc_d[k]    = DC_ONE;
          end
        end
        PRESS_CHK: begin
          if (!key_s[k]) begin
            state_d[k] = RELEASED;
            dc_d[k]    = '0;
          end else if (dc_q[k] == DC_MAX) begin
            state_d[k] = PRESSED;
            dc_d[k]    = '0;
            hc_d[k]    = '0;
            press_d[k] = 1'b1;
          end else begin
            dc_d[k] = dc_q[k] + DC_ONE;
          end
        end
        PRESSED: begin
          if (!key_s[k]) begin
            state_d[k] = RELEASE_CHK;
            dc_d[k]    = DC_ONE;
          end
        end
        RELEASE_CHK: begin
          if (key_s[k]) begin
            state_d[k] = PRESSED;
            dc_d[k]    = '0;
          end else if (dc_q[k] == DC_MAX) begin
            state_d[k]   = RELEASED;
            dc_d[k]      = '0;
            hc_d[k]      = '0;
            long_d[k]    = 1'b0;
            release_d[k] = 1'b1;
          end else begin
            dc_d[k] = dc_q[k] + DC_ONE;
          end
        end
      endcase

      level_d[k] = (state_d[k] == PRESSED) || (state_d[k] == RELEASE_CHK);
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_level   = level_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: a run-length reference model predicts the
// output vector after every clock edge into a queue; a monitor pops and
// compares at the falling edge. Directed scenarios add pulse-count and
// latency checks against fixed expectations.
module tb_key_press_conditioner;
  localparam int NK = 3;
  localparam int DB = 4;
  localparam int LG = 10;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [NK-1:0] keys_n = '1;
  logic [NK-1:0] o_press, o_release, o_long, o_level;

  always #5 clk = ~clk;

  key_press_conditioner #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_keys_n (keys_n),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_level  (o_level)
  );

  typedef logic [4*NK-1:0] vec_t;
  vec_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [NK-1:0] m_s1 = '1;
  logic [NK-1:0] m_s2 = '1;
  logic [NK-1:0] m_level = '0;
  int m_run [NK];
  int m_hold[NK];

  // pulses observed on the DUT
  int press_cnt[NK], rel_cnt[NK], long_cnt[NK];
  int last_press[NK], last_rel[NK], last_long[NK];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_level = '0;
    for (int k = 0; k < NK; k++) begin
      m_run[k]  = 0;
      m_hold[k] = 0;
    end
  endtask

  // A level change is accepted once the synchronized key has disagreed with
  // the debounced level for DB+1 consecutive edges; the hold time counts
  // edges since the press while the level is high.
  task automatic model_step(output vec_t v);
    logic [NK-1:0] p, r, l;
    logic s;
    logic was_level;
    p = '0; r = '0; l = '0;
    for (int k = 0; k < NK; k++) begin
      s = ~m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = keys_n[k];
      was_level = m_level[k];
      if (s != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DB + 1) begin
          m_level[k] = s;
          m_run[k]   = 0;
          m_hold[k]  = 0;
          if (s) p[k] = 1'b1;
          else   r[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
      if (was_level && !r[k] && m_hold[k] < LG) begin
        m_hold[k]++;
        if (m_hold[k] == LG) l[k] = 1'b1;
      end
    end
    v = {p, r, l, m_level};
  endtask

  initial begin
    int sp[NK], sr[NK], sl[NK];
    int e0;
    int c;
    logic lv;
    int dur[NK];

    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
      last_press[k] = -1; last_rel[k] = -1; last_long[k] = -1;
    end
    model_reset();

    fork
      // reference model: one expected vector per rising edge
      begin
        vec_t v;
        forever begin
          @(posedge clk);
          cyc++;
          if (!rst_n) begin
            model_reset();
            exp_q.push_back('0);
          end else begin
            model_step(v);
            exp_q.push_back(v);
          end
        end
      end
      // asynchronous reset clears outputs within the current cycle
      begin
        forever begin
          @(negedge rst_n);
          model_reset();
          if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
        end
      end
      // monitor
      begin
        vec_t want, got;
        forever begin
          @(negedge clk);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {o_press, o_release, o_long, o_level};
            total++;
            if (got !== want) begin
              bad++;
              $display("FAIL scoreboard cycle %0d: got press/rel/long/level=%h, want %h",
                       cyc, got, want);
            end
            for (int k = 0; k < NK; k++) begin
              if (o_press[k])   begin press_cnt[k]++; last_press[k] = cyc; end
              if (o_release[k]) begin rel_cnt[k]++;   last_rel[k]   = cyc; end
              if (o_long[k])    begin long_cnt[k]++;  last_long[k]  = cyc; end
            end
          end
        end
      end
      // stimulus
      begin
        // 1a: reset, all released, quiet for 20 cycles
        step(3);
        rst_n = 1'b1;
        sp = press_cnt; sr = rel_cnt; sl = long_cnt;
        step(20);
        for (int k = 0; k < NK; k++)
          check("quiet_pulses", press_cnt[k] + rel_cnt[k] + long_cnt[k] - sp[k] - sr[k] - sl[k], 0);

        // 1b: key 1 held through reset
        rst_n = 1'b0;
        keys_n[1] = 1'b0;
        step(3);
        rst_n = 1'b1;
        e0 = cyc + 1;
        sp = press_cnt;
        step(15);
        check("held_reset_press_cnt", press_cnt[1] - sp[1], 1);
        check("held_reset_press_cyc", last_press[1], e0 + 6);
        check("held_reset_level", int'(o_level[1]), 1);
        keys_n[1] = 1'b1;
        step(20);

        // 2: clean press / release on key 0
        sp = press_cnt; sr = rel_cnt; sl = long_cnt;
        keys_n[0] = 1'b0;
        e0 = cyc + 1;
        step(20);
        keys_n[0] = 1'b1;
        step(15);
        check("clean_press_cyc", last_press[0], e0 + 6);
        check("clean_long_cyc", last_long[0], e0 + 16);
        check("clean_release_cyc", last_rel[0], e0 + 26);
        check("clean_press_cnt", press_cnt[0] - sp[0], 1);

        // 3: bouncing press then bouncing release on key 2
        sp = press_cnt; sr = rel_cnt;
        c = 0; lv = 1'b0;
        while (c < 15) begin
          int w;
          w = $urandom_range(1, 3);
          keys_n[2] = lv;
          step(w);
          c += w;
          lv = ~lv;
        end
        if (lv) begin
          keys_n[2] = 1'b1;
          step($urandom_range(1, 3));
        end
        keys_n[2] = 1'b0;
        e0 = cyc + 1;
        step(20);
        check("bounce_press_cnt", press_cnt[2] - sp[2], 1);
        check("bounce_press_cyc", last_press[2], e0 + 6);
        c = 0; lv = 1'b1;
        while (c < 15) begin
          int w;
          w = $urandom_range(1, 3);
          keys_n[2] = lv;
          step(w);
          c += w;
          lv = ~lv;
        end
        if (!lv) begin
          keys_n[2] = 1'b0;
          step($urandom_range(1, 3));
        end
        keys_n[2] = 1'b1;
        e0 = cyc + 1;
        step(20);
        check("bounce_release_cnt", rel_cnt[2] - sr[2], 1);
        check("bounce_release_cyc", last_rel[2], e0 + 6);

        // 4a: short press, no long
        sp = press_cnt; sr = rel_cnt; sl = long_cnt;
        keys_n[0] = 1'b0;
        e0 = cyc + 1;
        step(8);
        keys_n[0] = 1'b1;
        step(25);
        check("short_press_cnt", press_cnt[0] - sp[0], 1);
        check("short_release_cyc", last_rel[0], e0 + 14);
        check("short_long_cnt", long_cnt[0] - sl[0], 0);

        // 4b: 2-cycle high glitch at hold cycle 5
        sr = rel_cnt; sl = long_cnt;
        keys_n[0] = 1'b0;
        e0 = cyc + 1;
        step(11);
        keys_n[0] = 1'b1;
        step(2);
        keys_n[0] = 1'b0;
        step(10);
        check("glitch_release_cnt", rel_cnt[0] - sr[0], 0);
        check("glitch_long_cnt", long_cnt[0] - sl[0], 1);
        check("glitch_long_cyc", last_long[0], e0 + 16);
        keys_n[0] = 1'b1;
        step(15);

        // 5: keys 0 and 2 together
        sp = press_cnt; sr = rel_cnt; sl = long_cnt;
        keys_n = 3'b010;
        e0 = cyc + 1;
        step(10);
        check("simul_press0_cyc", last_press[0], e0 + 6);
        check("simul_press2_cyc", last_press[2], e0 + 6);
        check("simul_key1_quiet", press_cnt[1] + rel_cnt[1] + long_cnt[1] - sp[1] - sr[1] - sl[1], 0);
        keys_n = '1;
        step(15);

        // 6: reset at hold cycle 5, key still held afterwards
        sp = press_cnt; sl = long_cnt;
        keys_n[1] = 1'b0;
        e0 = cyc + 1;
        step(12);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        e0 = cyc + 1;
        step(25);
        check("rst_hold_long_cnt", long_cnt[1] - sl[1], 1);
        check("rst_hold_press_cyc", last_press[1], e0 + 6);
        check("rst_hold_long_cyc", last_long[1], e0 + 16);
        keys_n[1] = 1'b1;
        step(15);

        // randomized run
        for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 30);
        repeat (3000) begin
          for (int k = 0; k < NK; k++) begin
            dur[k]--;
            if (dur[k] == 0) begin
              keys_n[k] = ~keys_n[k];
              dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(3, 40);
            end
          end
          if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            step($urandom_range(1, 3));
            rst_n = 1'b1;
          end
          step(1);
        end
        keys_n = '1;
        step(30);
      end
    join_any
    disable fork;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
